// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register window offsets,
// register-select encoding and the default line count.
package irq_pkg;

  localparam int DEFAULT_NIRQ = 8;

  localparam logic [3:0] OFF_PENDING = 4'h0;
  localparam logic [3:0] OFF_MASK    = 4'h4;
  localparam logic [3:0] OFF_ACTIVE  = 4'h8;
  localparam logic [3:0] OFF_OVERRUN = 4'hC;

  typedef enum logic [1:0] {
    SEL_PENDING = 2'(OFF_PENDING >> 2),
    SEL_MASK    = 2'(OFF_MASK >> 2),
    SEL_ACTIVE  = 2'(OFF_ACTIVE >> 2),
    SEL_OVERRUN = 2'(OFF_OVERRUN >> 2)
  } reg_sel_e;

  // Word select within the 16-byte window; byte lanes are ignored.
  function automatic reg_sel_e decode_sel(input logic [31:0] adr);
    return reg_sel_e'(adr[3:2]);
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector over all interrupt lines; irq_prev clears on reset so a
// line held high through reset reports one edge once reset is released.
module irq_edge_detect #(
  parameter int NIRQ = irq_pkg::DEFAULT_NIRQ
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  output logic [NIRQ-1:0] edges
);

  logic [NIRQ-1:0] irq_prev;

  always_ff @(posedge clk) begin
    if (reset) irq_prev <= '0;
    else       irq_prev <= irq_in;
  end

  assign edges = irq_in & ~irq_prev;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge-latched PENDING, MASK, OVERRUN and
// a registered interrupts output equal to PENDING & MASK.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          NIRQ      = DEFAULT_NIRQ
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            memwrite,
  input  logic [31:0]     dataadr,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic [NIRQ-1:0] interrupts
);

  logic [NIRQ-1:0] edges;
  logic [NIRQ-1:0] pending, mask, overrun;
  logic [NIRQ-1:0] pending_nxt, mask_nxt, overrun_nxt;
  logic [NIRQ-1:0] wdata, clr_pending, clr_overrun, rd_vec;
  logic            hit, wr;
  reg_sel_e        sel;
  logic            unused_bits;

  irq_edge_detect #(.NIRQ(NIRQ)) u_edge (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .edges  (edges)
  );

  assign unused_bits = ^{dataadr[1:0], writedata};

  always_comb begin
    hit   = (dataadr[31:4] == BASE_ADDR[31:4]);
    sel   = decode_sel(dataadr);
    wr    = memwrite & hit;
    wdata = writedata[NIRQ-1:0];

    clr_pending = (wr && sel == SEL_PENDING) ? wdata : '0;
    clr_overrun = (wr && sel == SEL_OVERRUN) ? wdata : '0;

    // Set beats clear: OR the new edges in after the W1C mask.
    pending_nxt = (pending & ~clr_pending) | edges;
    overrun_nxt = (overrun & ~clr_overrun) | (edges & pending);
    mask_nxt    = (wr && sel == SEL_MASK) ? wdata : mask;
  end

  // Register stage: interrupts is built from next-state values so a new edge
  // or mask write is visible right after the edge that captures it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      mask       <= '0;
      overrun    <= '0;
      interrupts <= '0;
    end else begin
      pending    <= pending_nxt;
      mask       <= mask_nxt;
      overrun    <= overrun_nxt;
      interrupts <= pending_nxt & mask_nxt;
    end
  end

  always_comb begin
    unique case (sel)
      SEL_PENDING: rd_vec = pending;
      SEL_MASK:    rd_vec = mask;
      SEL_ACTIVE:  rd_vec = pending & mask;
      SEL_OVERRUN: rd_vec = overrun;
      default:     rd_vec = '0;
    endcase
    readdata = '0;
    if (hit) readdata[NIRQ-1:0] = rd_vec;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clock port clk, reset port reset.
REQ-002 The module SHALL provide parameter BASE_ADDR, default 32'hFFFF_0000, meaning the base of a 16-byte register window.
REQ-003 The module SHALL provide parameter NIRQ, default 8, meaning the number of interrupt lines.
REQ-004 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 irq_in  input  NIRQ  raw device request lines, synchronous to clk, pulse or level.
REQ-007 memwrite  input  1  CPU store strobe.
REQ-008 dataadr  input  32  CPU byte address.
REQ-009 writedata  input  32  CPU store data.
REQ-010 readdata  output  32  register read data.
REQ-011 interrupts  output  NIRQ  request lines to the CPU.

Function
REQ-012 Register decode SHALL match dataadr[31:4] == BASE_ADDR[31:4], use dataadr[3:2] as the register select, and ignore dataadr[1:0].
- 0x0 PENDING: read; write-1-to-clear.
- 0x4 MASK: read/write.
- 0x8 ACTIVE: read-only, returns PENDING & MASK.
- 0xC OVERRUN: read; write-1-to-clear.
REQ-013 Rising-edge detect SHALL use a one-cycle delayed copy irq_prev: edge[i] = irq_in[i] & ~irq_prev[i].
REQ-014 An edge on line i SHALL set PENDING[i] at the same clock edge that samples it.
REQ-015 A held-high irq_in SHALL produce exactly one edge.
REQ-016 An edge on a line whose PENDING bit is already set SHALL set OVERRUN[i] and leave PENDING[i] at 1.
REQ-017 When a set and a W1C clear of the same bit occur in the same cycle, the set SHALL win; this applies to PENDING and to OVERRUN.
REQ-018 interrupts SHALL equal PENDING & MASK, driven from flops with no combinational path from irq_in.
REQ-019 Latency SHALL be one cycle: irq_in rises before edge k, and interrupts[i] is high after edge k when MASK[i]=1.
REQ-020 A MASK write SHALL take effect on interrupts after the write edge; masked lines SHALL still latch PENDING.
REQ-021 readdata SHALL be combinational from the decode: selected register in bits [NIRQ-1:0], upper bits 0, and 0 when the address is outside the window.
REQ-022 Stores outside the window, and writes to ACTIVE, SHALL have no effect.
REQ-023 Writedata bits at and above NIRQ SHALL be ignored.

Reset
REQ-024 On reset=1 at a clock edge, PENDING, MASK, OVERRUN, irq_prev and interrupts SHALL become 0; readdata then follows the zeroed registers.
REQ-025 Edges and stores SHALL be ignored during reset.
REQ-026 After reset, irq_prev SHALL be 0, so a line held high through reset SHALL register one edge on the first cycle after reset deasserts.

Structure
REQ-027 Shared package irq_pkg SHALL hold the register offsets (PENDING 0x0, MASK 0x4, ACTIVE 0x8, OVERRUN 0xC) and the default NIRQ.
REQ-028 One sub-module, irq_edge_detect (NIRQ-wide, containing irq_prev and the edge vector), SHALL be used.
REQ-029 The remaining register file and decode SHALL be implemented in irq_controller.

Verification
REQ-030 Reset, MASK=0x02, then a 1-cycle pulse on irq_in[1] -> interrupts=0x02 one cycle after the pulse; PENDING reads 0x02.
REQ-031 From REQ-030, store 0x02 to BASE+0x0 -> interrupts=0x00 after the store edge; PENDING reads 0.
REQ-032 With MASK=0, pulse irq_in[0] -> interrupts=0; then MASK=0x01 -> interrupts=0x01 the next cycle; ACTIVE reads 0x01.
REQ-033 Two pulses on irq_in[1], 9 cycles apart, with no clear -> PENDING=0x02, OVERRUN=0x02; store 0x02 to BASE+0xC clears OVERRUN.
REQ-034 Edge on irq_in[3] in the same cycle as a W1C of bit 3 to PENDING -> PENDING[3]=1 afterwards.
REQ-035 Hold irq_in[7] high across reset, then keep it high -> exactly one set of PENDING[7] after reset deasserts; a store to BASE+0x10 changes no register and readdata reads 0 there.
